mux_4_1: RTL and testbench

// - 4:1 multiplexer for 4-bit data, built by slicing the word into narrow
//   (2-bit) 4:1 mux lanes and concatenating the lane outputs.
// - Primary output y is purely combinational.
// - A registered copy y_q is provided for pipelined consumers; it is the

---
 rtl/mux_4_1_pkg.sv | 5 +
 rtl/mux_4_1_narrow.sv | 25 ++
 rtl/mux_4_1.sv | 46 ++++
 tb/tb_mux_4_1.sv | 90 +++++++++
 4 files changed

// File: rtl/mux_4_1_pkg.sv
// mux_4_1_pkg: shared input count and select type for the 4:1 mux slice
package mux_4_1_pkg;
    localparam int N_INPUTS = 4;
    typedef logic [1:0] sel_t;
endpackage

// File: rtl/mux_4_1_narrow.sv
// mux_4_1_narrow: one NARROW-bit 4:1 mux lane, purely combinational.
// Ports: d0..d3 lane data inputs, sel shared select, y selected lane data.
// An X/Z select falls to the default and yields all-X rather than d0.
module mux_4_1_narrow
    import mux_4_1_pkg::*;
#(
    parameter int NARROW = 2
) (
    input  logic [NARROW-1:0] d0,
    input  logic [NARROW-1:0] d1,
    input  logic [NARROW-1:0] d2,
    input  logic [NARROW-1:0] d3,
    input  sel_t              sel,
    output logic [NARROW-1:0] y
);
    always_comb begin
        y = 'x;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end
endmodule

// File: rtl/mux_4_1.sv
// mux_4_1: WIDTH-bit 4:1 mux built from NARROW-bit lanes, plus a registered copy.
// Ports: clk rising-edge clock (y_q only), rst_n async active-low reset (y_q only),
// d0..d3 data inputs, sel select, y combinational output, y_q y registered on clk.
module mux_4_1
    import mux_4_1_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NARROW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);
    logic [WIDTH-1:0] y_d;

    if (WIDTH % NARROW != 0) begin : g_bad_width
        $error("mux_4_1: WIDTH must be a multiple of NARROW");
    end
    if ($bits(sel_t) != $clog2(N_INPUTS)) begin : g_bad_sel
        $error("mux_4_1: sel_t width does not match N_INPUTS");
    end

    for (genvar i = 0; i < WIDTH / NARROW; i++) begin : g_lane
        mux_4_1_narrow #(.NARROW(NARROW)) u_lane (
            .d0  (d0[i*NARROW +: NARROW]),
            .d1  (d1[i*NARROW +: NARROW]),
            .d2  (d2[i*NARROW +: NARROW]),
            .d3  (d3[i*NARROW +: NARROW]),
            .sel (sel),
            .y   (y[i*NARROW +: NARROW])
        );
    end

    always_comb y_d = y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= '0;
        else        y_q <= y_d;
    end
endmodule

// File: tb/tb_mux_4_1.sv
// tb_mux_4_1: directed checks of the combinational select and the y_q register
module tb_mux_4_1;
    import mux_4_1_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d0, d1, d2, d3;
    sel_t       sel;
    logic [3:0] y, y_q;
    int         n_checks = 0;
    int         n_fails  = 0;

    mux_4_1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .sel   (sel),
        .y     (y),
        .y_q   (y_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_abcd [4];
        exp_abcd = '{4'ha, 4'hb, 4'hc, 4'hd};
        rst_n = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        sel = 2'd0;
        #1 check("reset_yq", y_q, 4'h0);

        d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
        for (int i = 0; i < 4; i++) begin
            sel = sel_t'(i);
            #1 check($sformatf("sweep_sel%0d", i), y, exp_abcd[i]);
        end

        d0 = 4'h7; d1 = 4'ha; d2 = 4'h3; d3 = 'x;
        sel = 2'd0; #1 check("xd3_sel0", y, 4'h7);
        sel = 2'd1; #1 check("xd3_sel1", y, 4'ha);
        sel = 2'd2; #1 check("xd3_sel2", y, 4'h3);
        sel = 2'd3; #1 check("xd3_sel3", y, 4'bxxxx);

        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        sel = 'x;   #1 check("sel_x", y, 4'bxxxx);

        d0 = 4'b0011; d1 = 4'b1100; d2 = 4'h0; d3 = 4'h0;
        sel = 2'd0; #1 check("lane_sel0", y, 4'b0011);
        sel = 2'd1; #1 check("lane_sel1", y, 4'b1100);
        check("yq_held_in_reset", y_q, 4'h0);

        @(negedge clk);
        rst_n = 1'b1;
        d1 = 4'h5; sel = 2'd1;
        #1 check("yq_before_edge", y_q, 4'h0);
        @(posedge clk); #1;
        check("yq_capture", y_q, 4'h5);

        @(negedge clk);
        rst_n = 1'b0;
        #1 check("async_reset", y_q, 4'h0);
        check("y_during_reset", y, 4'h5);

        @(negedge clk);
        rst_n = 1'b1;
        #1 check("yq_after_release", y_q, 4'h0);
        @(posedge clk); #1;
        check("yq_first_capture", y_q, 4'h5);

        d2 = 4'h9; sel = 2'd2;
        #1 check("y_tracks_sel", y, 4'h9);
        check("yq_lags", y_q, 4'h5);
        @(posedge clk); #1;
        check("yq_next", y_q, 4'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
